// File: rtl/i2c_pkg.sv
// Shared I2C definitions: master FSM states, quarter-phase type, device
// address, and the per-quarter line drive table.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    START,
    ADDR,
    ADDR_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RDATA_NACK,
    STOP
  } i2c_master_state_t;

  // Position within a bit slot: Q0..Q3
  typedef logic [1:0] quarter_t;

  // Address acknowledged by the target-side receiver
  localparam logic [6:0] I2C_DEV_ADDR = 7'h42;

  // Open-drain pull-down enables {scl_low, sda_low} for a given state and
  // quarter; bit_val is the data bit being sent in ADDR/WDATA slots.
  function automatic logic [1:0] line_drive(input i2c_master_state_t st,
                                            input quarter_t q,
                                            input logic bit_val);
    logic scl_low;
    logic sda_low;
    scl_low = 1'b0;
    sda_low = 1'b0;
    case (st)
      START: begin
        sda_low = (q >= 2'd2);
      end
      ADDR, WDATA: begin
        scl_low = (q < 2'd2);
        sda_low = !bit_val;
      end
      ADDR_ACK, WDATA_ACK, RDATA, RDATA_NACK: begin
        scl_low = (q < 2'd2);
      end
      STOP: begin
        scl_low = (q < 2'd2);
        sda_low = (q != 2'd3);
      end
      default: begin
        scl_low = 1'b0;
        sda_low = 1'b0;
      end
    endcase
    return {scl_low, sda_low};
  endfunction

endpackage

// File: rtl/i2c_tick_gen.sv
// Quarter-SCL-period divider: counts clk100 cycles 0..CLK_DIV-1, fires a
// one-cycle tick on the last count and advances the 2-bit quarter index.
module i2c_tick_gen
  import i2c_pkg::*;
#(
  parameter int unsigned CLK_DIV = 250
) (
  input  logic     clk100,
  input  logic     reset,
  input  logic     en,
  output logic     tick,
  output quarter_t quarter
);

  localparam int unsigned CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == LAST);

  // Divider counter and quarter index; held at zero while disabled
  always_ff @(posedge clk100) begin
    if (!reset || !en) begin
      cnt     <= '0;
      quarter <= '0;
    end else if (tick) begin
      cnt     <= '0;
      quarter <= quarter + 2'd1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/i2c_master.sv
// Single-byte I2C master: START, 7-bit address + R/W, one data byte
// (write or read), STOP, on open-drain SCL/SDA. No stretching, no arbitration.
module i2c_master
  import i2c_pkg::*;
#(
  parameter int unsigned CLK_DIV = 250
) (
  input  logic       clk100,
  input  logic       reset,
  input  logic       start,
  input  logic [6:0] addr,
  input  logic       rw,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic       nack,
  output logic [7:0] rdata,
  inout  wire        ck_scl,
  inout  wire        ck_sda
);

  i2c_master_state_t state;
  i2c_master_state_t nxt_state;
  logic [3:0]        bit_cnt;
  logic [3:0]        nxt_cnt;
  logic [7:0]        shreg;
  logic [7:0]        nxt_sh;
  logic [7:0]        wdata_q;
  logic [7:0]        rx;
  logic              rw_q;
  logic              sda_smp;
  logic              scl_low;
  logic              sda_low;
  logic              tick;
  quarter_t          quarter;
  quarter_t          nq;
  i2c_master_state_t drv_state;
  logic              drv_bit;
  logic [1:0]        drv;

  i2c_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk100  (clk100),
    .reset   (reset),
    .en      (state != IDLE),
    .tick    (tick),
    .quarter (quarter)
  );

  assign ck_scl = scl_low ? 1'b0 : 1'bz;
  assign ck_sda = sda_low ? 1'b0 : 1'bz;

  // Slot-end transition: next state, bit counter and shift register,
  // applied only on the Q3 tick
  always_comb begin
    nxt_state = state;
    nxt_cnt   = bit_cnt;
    nxt_sh    = shreg;
    case (state)
      START: begin
        nxt_state = ADDR;
        nxt_cnt   = '0;
      end
      ADDR: begin
        nxt_sh = {shreg[6:0], 1'b0};
        if (bit_cnt == 4'd7) begin
          nxt_state = ADDR_ACK;
          nxt_cnt   = 4'd8;
        end else begin
          nxt_cnt = bit_cnt + 4'd1;
        end
      end
      ADDR_ACK: begin
        nxt_cnt = '0;
        if (sda_smp) begin
          nxt_state = STOP;
        end else if (rw_q) begin
          nxt_state = RDATA;
        end else begin
          nxt_state = WDATA;
          nxt_sh    = wdata_q;
        end
      end
      WDATA: begin
        nxt_sh = {shreg[6:0], 1'b0};
        if (bit_cnt == 4'd7) begin
          nxt_state = WDATA_ACK;
          nxt_cnt   = 4'd8;
        end else begin
          nxt_cnt = bit_cnt + 4'd1;
        end
      end
      WDATA_ACK: begin
        nxt_state = STOP;
        nxt_cnt   = '0;
      end
      RDATA: begin
        if (bit_cnt == 4'd7) begin
          nxt_state = RDATA_NACK;
          nxt_cnt   = 4'd8;
        end else begin
          nxt_cnt = bit_cnt + 4'd1;
        end
      end
      RDATA_NACK: begin
        nxt_state = STOP;
        nxt_cnt   = '0;
      end
      STOP: begin
        nxt_state = IDLE;
        nxt_cnt   = '0;
      end
      default: begin
        nxt_state = IDLE;
        nxt_cnt   = '0;
      end
    endcase
  end

  // Drive enables for the quarter that begins after this tick; across a slot
  // boundary they come from the post-transition state and shift register.
  always_comb begin
    nq        = quarter + 2'd1;
    drv_state = (quarter == 2'd3) ? nxt_state : state;
    drv_bit   = (quarter == 2'd3) ? nxt_sh[7] : shreg[7];
    drv       = line_drive(drv_state, nq, drv_bit);
  end

  // Main controller: request capture, per-tick line updates, SDA sampling,
  // slot transitions and completion outputs
  always_ff @(posedge clk100) begin
    if (!reset) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      wdata_q <= '0;
      rx      <= '0;
      rw_q    <= 1'b0;
      sda_smp <= 1'b1;
      scl_low <= 1'b0;
      sda_low <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      nack    <= 1'b0;
      rdata   <= '0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start && !done) begin
          state   <= START;
          bit_cnt <= '0;
          shreg   <= {addr, rw};
          rw_q    <= rw;
          wdata_q <= wdata;
          busy    <= 1'b1;
          nack    <= 1'b0;
        end
      end else if (tick) begin
        scl_low <= drv[1];
        sda_low <= drv[0];
        if (quarter == 2'd2) begin
          sda_smp <= ck_sda;
          if (state == RDATA) begin
            rx <= {rx[6:0], ck_sda};
          end
        end
        if (quarter == 2'd3) begin
          state   <= nxt_state;
          bit_cnt <= nxt_cnt;
          shreg   <= nxt_sh;
          if ((state == ADDR_ACK || state == WDATA_ACK) && sda_smp) begin
            nack <= 1'b1;
          end
          if (state == STOP) begin
            done <= 1'b1;
            busy <= 1'b0;
            if (rw_q && !nack) begin
              rdata <= rx;
            end
          end
        end
      end
    end
  end

endmodule

// File: doc/i2c_master.md
# i2c_master

Single-byte I2C bus controller that generates START, address + R/W, one data byte (write or read), and STOP on an open-drain SCL/SDA pair. It is the initiator counterpart to the team's I2C target-side address receiver, which acknowledges address 0x42, and drives the same `ck_scl`/`ck_sda` pins in bench loopback and on the board. There is no clock stretching and no multi-master arbitration. Transfers are exactly one address byte plus one data byte.

## Interface
- `CLK_DIV`, default 250: `clk100` cycles per quarter SCL period (250 gives 100 kHz). Legal range 2..1023.
- `clk100`  in  1  system clock.
- `reset`  in  1  reset; one clock, synchronous, active-low (asserted when 0).
- `start`  in  1  request pulse; sampled only in IDLE.
- `addr`  in  7  target address; captured on accepted `start`.
- `rw`  in  1  0 = write, 1 = read; captured on accepted `start`.
- `wdata`  in  8  write byte; captured on accepted `start`.
- `busy`  out  1  high from the cycle after an accepted `start` until `done`.
- `done`  out  1  one-cycle pulse at the end of a transfer.
- `nack`  out  1  valid with `done`: 1 = address or write byte not acknowledged. Held until the next accepted `start`.
- `rdata`  out  8  read byte; valid with `done` when `rw`=1 and `nack`=0. Held afterwards.
- `ck_scl`  inout  1  driven 0 or released ('bz). Never driven 1.
- `ck_sda`  inout  1  driven 0 or released ('bz). Never driven 1.

## Operation
- Reset values: `busy`=0, `done`=0, `nack`=0, `rdata`=0; both lines released; state IDLE; quarter counter 0.
- Phases:
  - Each bit slot is 4 quarters, Q0..Q3.
  - SCL is low in Q0–Q1 and released in Q2–Q3.
  - SDA changes only at the Q0 start.
  - SDA is sampled on the last `clk100` cycle of Q2.
- States and transitions:
  - IDLE -> START on `start`. `addr`/`rw`/`wdata` are latched into a shift register holding {addr, rw}.
  - START (4 quarters): SCL released throughout; SDA released in Q0–Q1, driven low in Q2–Q3.
  - ADDR: 8 bit slots, MSB first, shifting {addr, rw}. A bit value of 1 means release SDA.
  - ADDR_ACK: 1 slot with SDA released; sample the line.
    - Sampled 1 -> `nack`=1, go to STOP.
    - Sampled 0 -> go to WDATA when rw=0, or RDATA when rw=1.
  - WDATA: 8 slots, MSB first. Then WDATA_ACK: 1 slot with SDA released; a sampled 1 sets `nack`. Then STOP.
  - RDATA: 8 slots with SDA released; sampled bits shift into `rdata`, MSB first. Then RDATA_NACK: 1 slot with SDA released (master NACK), then STOP.
  - STOP (4 quarters): SDA driven low in Q0–Q2 and released in Q3. SCL low in Q0–Q1, released in Q2–Q3.
  - After STOP: `done`=1 for one cycle, `busy`=0 in the same cycle, return to IDLE.
- A `start` received while `busy`=1, or in the `done` cycle, is ignored (not queued).
- Reset asserted mid-transfer: on the next clock, both lines are released, state is IDLE, and all outputs return to reset values. No STOP is generated.
- SCL is never sampled, so a target holding SCL low is not detected.

## Timing
- `busy` rises 1 cycle after the `start` cycle.
- The START Q0 begins in the same cycle `busy` rises.
- Transfer length, counted from `busy` rising to the `done` cycle inclusive:
  - Full transfer (write or read): 80·`CLK_DIV` cycles (4 + 36 + 36 + 4 quarters).
  - Address NACK: 44·`CLK_DIV` cycles.
- Quarter counter: counts 0..`CLK_DIV`-1 and wraps; a tick fires at the wrap.
- Bit counter: 0..8 within a byte phase (8 data bits + ACK slot) and wraps at the phase change.
- `done` and `busy` fall are registered; no combinational path from inputs to outputs.
- Line drive enables are registered and switch on tick boundaries only.

## Structure
- Shared package `i2c_pkg`:
  - state enum `i2c_master_state_t` {IDLE, START, ADDR, ADDR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_NACK, STOP};
  - quarter-phase type;
  - `I2C_DEV_ADDR` = 7'h42, shared with the target-side receiver.
- Sub-module `i2c_tick_gen`:
  - the parameterised `CLK_DIV` quarter-period divider, with synchronous active-low reset and an enable;
  - outputs a 1-cycle `tick` and a 2-bit `quarter`.

## Test plan
- Reset: hold `reset`=0 for 3 cycles with `CLK_DIV`=4 -> lines released ('bz, pulled up to 1); `busy`=0, `done`=0, `nack`=0, `rdata`=0.
- Write to 0x42: `start`, `addr`=0x42, `rw`=0, `wdata`=0xA5, bench target ACKs both bytes -> SDA bytes 0x84 then 0xA5 at SCL rises; `nack`=0; `done` exactly 320 cycles after `busy` rises; STOP observed (SDA rises while SCL is high).
- Address NACK: `addr`=0x13, no target -> `nack`=1; `done` at 176 cycles; no data-phase SCL pulses after the 9th.
- Read: `addr`=0x42, `rw`=1, bench target drives 0x3C -> `rdata`=0x3C, `nack`=0; SDA released during the 9th data slot; STOP follows.
- Loopback with the target-side receiver at `CLK_DIV`=250: write to 0x42 -> receiver raises `ack_in_progress_w` during ADDR_ACK, and the master sees an address ACK.
- Robustness:
  - `start` pulsed during ADDR -> ignored; the transfer completes unchanged.
  - `reset`=0 in bit 3 of ADDR -> both lines released next cycle, `busy`=0, no `done`.
